// File: rtl/asrv32_mem_arbiter.sv
// asrv32_mem_arbiter: shares one memory stb/ack port between the fetch and
// data ports of the core. Data wins conflicts unless fetch has been passed
// over STARVE_LIMIT times in a row. A WAIT timeout returns an error ack.
module asrv32_mem_arbiter #(
  parameter int STARVE_LIMIT   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // instruction fetch side
  input  logic        i_inst_stb,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_ack,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_err,
  // data side
  input  logic        i_data_stb,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic        i_data_wr_en,
  input  logic [3:0]  i_data_wr_mask,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic        o_data_err,
  // memory side
  output logic        o_mem_stb,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wr_en,
  output logic [3:0]  o_mem_wr_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_next;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_to_cnt;
  logic            r_win_inst;
  logic            r_err;
  logic [31:0]     r_mem_addr, r_mem_wdata, r_inst_rdata, r_data_rdata;
  logic            r_mem_wr_en;
  logic [3:0]      r_mem_wr_mask;

  logic w_any_req, w_grant_inst, w_got_ack, w_timeout, w_to_resp;

  assign w_any_req    = i_inst_stb | i_data_stb;
  // fetch wins when alone, or when it has been starved long enough
  assign w_grant_inst = i_inst_stb & (~i_data_stb | (r_starve >= SLIM));
  assign w_got_ack    = (r_state == S_WAIT) & i_mem_ack;
  assign w_timeout    = (r_state == S_WAIT) & ~i_mem_ack & (r_to_cnt == TLAST);
  assign w_to_resp    = w_got_ack | w_timeout;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic; RESP always returns to IDLE so no grant overlaps an ack
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_to_resp) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // grant capture, starvation/timeout counters and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve      <= '0;
      r_to_cnt      <= '0;
      r_win_inst    <= 1'b0;
      r_err         <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_mask <= '0;
      r_inst_rdata  <= '0;
      r_data_rdata  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_win_inst <= w_grant_inst;
        r_to_cnt   <= '0;
        if (w_grant_inst) begin
          r_starve      <= '0;
          r_mem_addr    <= i_inst_addr;
          r_mem_wdata   <= '0;
          r_mem_wr_en   <= 1'b0;
          r_mem_wr_mask <= '0;
        end else begin
          if (i_inst_stb && r_starve != SLIM) r_starve <= r_starve + 1'b1;
          r_mem_addr    <= i_data_addr;
          r_mem_wdata   <= i_data_wdata;
          r_mem_wr_en   <= i_data_wr_en;
          r_mem_wr_mask <= i_data_wr_mask;
        end
      end
      if (r_state == S_WAIT && !w_to_resp) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_resp) begin
        // a timed-out access returns zero data; stores always return zero
        r_err <= ~i_mem_ack;
        if (r_win_inst) r_inst_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
        else            r_data_rdata <= (i_mem_ack && !r_mem_wr_en) ? i_mem_rdata : 32'h0;
      end
    end
  end

  assign o_mem_stb     = (r_state == S_ISSUE);
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_wr_en   = r_mem_wr_en;
  assign o_mem_wr_mask = r_mem_wr_mask;
  assign o_busy        = (r_state != S_IDLE);

  assign o_inst_ack    = (r_state == S_RESP) &  r_win_inst;
  assign o_data_ack    = (r_state == S_RESP) & ~r_win_inst;
  assign o_inst_err    = o_inst_ack & r_err;
  assign o_data_err    = o_data_ack & r_err;
  assign o_inst_rdata  = r_inst_rdata;
  assign o_data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// Directed bench for asrv32_mem_arbiter: fetch, store, starvation order,
// timeout, reset mid-transaction and back-to-back spacing.
module tb_asrv32_mem_arbiter;

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_stb = 0;  logic [31:0] inst_addr = 0;
  logic        inst_ack;      logic [31:0] inst_rdata; logic inst_err;
  logic        data_stb = 0;  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_wr_en = 0; logic [3:0] data_wr_mask = 0;
  logic        data_ack;      logic [31:0] data_rdata; logic data_err;
  logic        mem_stb;       logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr_en;     logic [3:0]  mem_wr_mask;
  logic        mem_ack = 0;   logic [31:0] mem_rdata = 0;
  logic        busy;

  int n_chk = 0, n_err = 0;
  logic mem_auto = 1'b1;
  logic prev_stb = 1'b0;

  asrv32_mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_stb(inst_stb), .i_inst_addr(inst_addr),
    .o_inst_ack(inst_ack), .o_inst_rdata(inst_rdata), .o_inst_err(inst_err),
    .i_data_stb(data_stb), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .i_data_wr_en(data_wr_en), .i_data_wr_mask(data_wr_mask),
    .o_data_ack(data_ack), .o_data_rdata(data_rdata), .o_data_err(data_err),
    .o_mem_stb(mem_stb), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wr_en(mem_wr_en), .o_mem_wr_mask(mem_wr_mask),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  // memory model: acks in the cycle after o_mem_stb
  always @(negedge clk) begin
    if (mem_auto) begin
      mem_ack   = prev_stb;
      mem_rdata = prev_stb ? mem_word(mem_addr) : 32'h0;
    end
    prev_stb = mem_stb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int k, hit;
  int t_ack [3];
  logic order [6];
  logic exp_order [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset mem_stb", mem_stb, 0);
    check("reset acks", {inst_ack, data_ack}, 0);

    // fetch only
    inst_stb = 1; inst_addr = 32'h40;
    tick();
    check("fetch mem_stb N+1", mem_stb, 1);
    check("fetch mem_addr", mem_addr, 32'h40);
    check("fetch wr_en", mem_wr_en, 0);
    tick();
    check("fetch wait stb low", mem_stb, 0);
    check("fetch wait addr", mem_addr, 32'h40);
    tick();
    check("fetch ack N+3", inst_ack, 1);
    check("fetch rdata", inst_rdata, 32'h0050_0093);
    check("fetch err", inst_err, 0);
    check("fetch no data ack", data_ack, 0);
    inst_stb = 0;
    tick();
    check("fetch ack pulse", inst_ack, 0);
    check("fetch idle", busy, 0);

    // store
    data_stb = 1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    data_wr_en = 1; data_wr_mask = 4'b0011;
    tick();
    check("store mem_stb", mem_stb, 1);
    check("store addr", mem_addr, 32'h100);
    check("store wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store wr_en", mem_wr_en, 1);
    check("store mask", mem_wr_mask, 4'b0011);
    tick();
    check("store wait wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store wait mask", mem_wr_mask, 4'b0011);
    tick();
    check("store ack", data_ack, 1);
    check("store rdata zero", data_rdata, 0);
    check("store err", data_err, 0);
    data_stb = 0; data_wr_en = 0; data_wr_mask = 0;
    tick();

    // starvation guard: both requesters held high
    inst_stb = 1; inst_addr = 32'h200;
    data_stb = 1; data_addr = 32'h300;
    for (int t = 0; t < 6; t++) begin
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
        tick();
        if (mem_stb) hit = 1;
      end
      check("starve grant seen", hit, 1);
      order[t] = (mem_addr == 32'h200);
      check("starve grant order", order[t], exp_order[t]);
      tick(); tick();
      check("starve inst ack", inst_ack, exp_order[t]);
      check("starve data ack", data_ack, !exp_order[t]);
      if (exp_order[t]) check("starve inst rdata", inst_rdata, 32'hA5A5_0200);
      else              check("starve data rdata", data_rdata, 32'hA5A5_0300);
    end
    inst_stb = 0; data_stb = 0;
    tick();

    // timeout
    mem_auto = 0; mem_ack = 0;
    data_stb = 1; data_addr = 32'h500;
    k = 0;
    for (int c = 1; c <= 30 && k == 0; c++) begin
      tick();
      if (data_ack) k = c;
    end
    check("timeout ack at N+18", k, 18);
    check("timeout err", data_err, 1);
    check("timeout rdata", data_rdata, 0);
    data_stb = 0;
    tick();
    check("timeout back to idle", busy, 0);
    mem_auto = 1;
    data_stb = 1; data_addr = 32'h600;
    tick(); tick(); tick();
    check("after timeout ack", data_ack, 1);
    check("after timeout rdata", data_rdata, 32'hA5A5_0600);
    check("after timeout err", data_err, 0);
    data_stb = 0;
    tick();

    // reset mid-transaction, late memory ack
    mem_auto = 0; mem_ack = 0;
    inst_stb = 1; inst_addr = 32'h700;
    tick(); tick();
    check("rst wait state", busy, 1);
    rst = 1;
    tick();
    rst = 0; inst_stb = 0; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    check("rst busy", busy, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst inst_rdata", inst_rdata, 0);
    check("rst data_rdata", data_rdata, 0);
    check("rst acks", {inst_ack, data_ack, inst_err, data_err, mem_stb}, 0);
    tick();
    mem_ack = 0;
    check("late ack ignored acks", {inst_ack, data_ack}, 0);
    check("late ack busy", busy, 0);
    tick();
    check("late ack no resp", {inst_ack, data_ack}, 0);
    mem_auto = 1;

    // back-to-back fetches
    inst_stb = 1; inst_addr = 32'h800;
    k = 0;
    for (int c = 1; c <= 20 && k < 3; c++) begin
      tick();
      if (inst_ack) begin
        t_ack[k] = c;
        k++;
        check("b2b no stb in resp", mem_stb, 0);
      end
    end
    inst_stb = 0;
    check("b2b ack count", k, 3);
    check("b2b first ack", t_ack[0], 3);
    check("b2b spacing 1", t_ack[1] - t_ack[0], 4);
    check("b2b spacing 2", t_ack[2] - t_ack[1], 4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
